vuart_dev_seq: RTL

VUART_DEV_SEQ -- requirements
Module: vuart_dev_seq

---
 rtl/vuart_dev_seq_pkg.sv | 26 ++
 rtl/vuart_dev_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vuart_dev_seq_pkg.sv
// Shared vuart register map (device-port offsets, STAT bit layout) and the
// sequencer state encoding used by the APB-master side.
package vuart_dev_seq_pkg;

  localparam logic [15:0] VUART_ADDR_STAT      = 16'h0000;
  localparam logic [15:0] VUART_ADDR_FIFO      = 16'h0008;
  localparam int          VUART_STAT_RXVLD_BIT = 0;
  localparam int          VUART_STAT_TXRDY_BIT = 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    STAT_SETUP  = 3'd1,
    STAT_ACCESS = 3'd2,
    TX_SETUP    = 3'd3,
    TX_ACCESS   = 3'd4,
    RX_SETUP    = 3'd5,
    RX_ACCESS   = 3'd6,
    GAP         = 3'd7
  } seq_state_e;

  // FIFO writes carry the byte in the low lane, upper lanes zero.
  function automatic logic [31:0] fifo_wdata(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/vuart_dev_seq.sv
// Byte-stream to APB vuart sequencer: STAT poll before every FIFO access; TX byte
// completes 5 cycles after capture (pready=1); tx stalls on full hold, rx holds until rx_ready.
module vuart_dev_seq
  import vuart_dev_seq_pkg::*;
#(
  parameter logic [15:0] ADDR_STAT      = VUART_ADDR_STAT,
  parameter logic [15:0] ADDR_FIFO      = VUART_ADDR_FIFO,
  parameter int          STAT_RXVLD_BIT = VUART_STAT_RXVLD_BIT,
  parameter int          STAT_TXRDY_BIT = VUART_STAT_TXRDY_BIT,
  parameter int          POLL_GAP       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic        rx_enable,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        err,
  input  logic        err_clr,
  output logic        busy
);

  localparam logic [7:0] GAP_LOAD = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

  seq_state_e state;
  logic       hold_vld;
  logic [7:0] hold_dat;
  logic       last_tx;
  logic [7:0] gap_cnt;
  logic       tx_ok;
  logic       rx_ok;

  assign tx_ready = !hold_vld;
  assign busy     = (state != IDLE);
  assign tx_ok    = hold_vld && prdata[STAT_TXRDY_BIT];
  assign rx_ok    = rx_enable && !rx_valid && prdata[STAT_RXVLD_BIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      hold_vld <= 1'b0;
      hold_dat <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      err      <= 1'b0;
      last_tx  <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      if (tx_valid && tx_ready) begin
        hold_vld <= 1'b1;
        hold_dat <= tx_data;
      end
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A bus error later in this block overrides the clear.
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (hold_vld || (rx_enable && !rx_valid)) begin
            state   <= STAT_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= ADDR_STAT;
            pwdata  <= '0;
          end
        end

        STAT_SETUP: begin
          state   <= STAT_ACCESS;
          penable <= 1'b1;
        end

        STAT_ACCESS: begin
          if (pready) begin
            penable <= 1'b0;
            if (pslverr) begin
              err   <= 1'b1;
              psel  <= 1'b0;
              state <= IDLE;
            end else if (tx_ok && (!rx_ok || !last_tx)) begin
              // psel stays high: the data access SETUP follows back-to-back.
              state   <= TX_SETUP;
              pwrite  <= 1'b1;
              paddr   <= ADDR_FIFO;
              pwdata  <= fifo_wdata(hold_dat);
              last_tx <= 1'b1;
            end else if (rx_ok) begin
              state   <= RX_SETUP;
              pwrite  <= 1'b0;
              paddr   <= ADDR_FIFO;
              last_tx <= 1'b0;
            end else begin
              psel    <= 1'b0;
              gap_cnt <= GAP_LOAD;
              state   <= (POLL_GAP == 0) ? IDLE : GAP;
            end
          end
        end

        TX_SETUP: begin
          state   <= TX_ACCESS;
          penable <= 1'b1;
        end

        TX_ACCESS: begin
          if (pready) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            hold_vld <= 1'b0;
            if (pslverr) begin
              err <= 1'b1;
            end
            state <= IDLE;
          end
        end

        RX_SETUP: begin
          state   <= RX_ACCESS;
          penable <= 1'b1;
        end

        RX_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              err <= 1'b1;
            end else begin
              rx_valid <= 1'b1;
              rx_data  <= prdata[7:0];
            end
            state <= IDLE;
          end
        end

        GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule
